block_lock_fsm: RTL



---
 rtl/block_lock_fsm.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/block_lock_fsm.sv
// Receive-side 64b/66b block-lock controller: tests sync headers, commands gearbox slips, drives block_lock.
// Optional high-BER monitor compiled in with `define BLOCK_LOCK_HIBER_EN.
module block_lock_fsm #(
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned SH_WINDOW    = 64,
  parameter int unsigned INVLD_LIMIT  = 16,
  parameter int unsigned SLIP_WAIT    = 32,
  parameter int unsigned HIBER_WINDOW = 195313
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [HDR_WIDTH-1:0]               i_rx_hdr,
  input  logic                               i_rx_hdr_valid,
  output logic                               o_block_lock,
  output logic                               o_slip,
  output logic [$clog2(INVLD_LIMIT+1)-1:0]   o_sh_invld_cnt,
  output logic                               o_hi_ber
);

  localparam int unsigned SH_W   = $clog2(SH_WINDOW + 1);
  localparam int unsigned INV_W  = $clog2(INVLD_LIMIT + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_MAX   = SH_W'(SH_WINDOW);
  localparam logic [INV_W-1:0]  INV_MAX  = INV_W'(INVLD_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(SLIP_WAIT);

  // Handshake: i_rx_hdr is sampled only on cycles with i_rx_hdr_valid=1; there is
  // no backpressure. o_slip is a single-cycle command, never on consecutive cycles.
  typedef enum logic [1:0] {
    ST_RESET_CNT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP      = 2'd2,
    ST_WAIT      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]    invld_q, invld_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                lock_q, lock_d;
  logic                slip_q, slip_d;

  logic                hdr_ok;
  logic [SH_W-1:0]     sh_cnt_inc;
  logic [INV_W-1:0]    invld_inc;
  logic                win_end;

  assign hdr_ok = (i_rx_hdr == HDR_WIDTH'(2'b01)) || (i_rx_hdr == HDR_WIDTH'(2'b10));

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    invld_d    = invld_q;
    wait_d     = wait_q;
    lock_d     = lock_q;
    sh_cnt_inc = (sh_cnt_q == SH_MAX) ? sh_cnt_q : sh_cnt_q + 1'b1;
    invld_inc  = (invld_q == INV_MAX) ? invld_q : invld_q + 1'b1;
    win_end    = (sh_cnt_inc == SH_MAX);

    case (state_q)
      ST_RESET_CNT: begin
        sh_cnt_d = '0;
        invld_d  = '0;
        state_d  = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (i_rx_hdr_valid) begin
          sh_cnt_d = sh_cnt_inc;
          if (hdr_ok) begin
            if (win_end) begin
              if (invld_q == '0) lock_d = 1'b1;
              state_d = ST_RESET_CNT;
            end
          end else begin
            invld_d = invld_inc;
            // Hitting the invalid limit wins over a simultaneous window end.
            if (!lock_q || (invld_inc == INV_MAX)) begin
              state_d = ST_SLIP;
              lock_d  = 1'b0;
            end else if (win_end) begin
              state_d = ST_RESET_CNT;
            end
          end
        end
      end
      ST_SLIP: begin
        lock_d  = 1'b0;
        wait_d  = WAIT_LD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_rx_hdr_valid) begin
          if (wait_q <= WAIT_W'(1)) begin
            wait_d  = '0;
            state_d = ST_RESET_CNT;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
      end
      default: state_d = ST_RESET_CNT;
    endcase

    slip_d = (state_d == ST_SLIP) && (state_q != ST_SLIP);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= ST_RESET_CNT;
      sh_cnt_q <= '0;
      invld_q  <= '0;
      wait_q   <= '0;
      lock_q   <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      invld_q  <= invld_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      slip_q   <= slip_d;
    end
  end

  assign o_block_lock   = lock_q;
  assign o_slip         = slip_q;
  assign o_sh_invld_cnt = invld_q;

`ifdef BLOCK_LOCK_HIBER_EN
  localparam int unsigned HB_W    = $clog2(HIBER_WINDOW);
  localparam int unsigned BER_LIM = 16;
  localparam int unsigned BER_W   = $clog2(BER_LIM + 1);

  logic [HB_W-1:0]  hb_cnt_q;
  logic [BER_W-1:0] ber_cnt_q;
  logic             hi_ber_q;
  logic             hb_end;

  assign hb_end = (hb_cnt_q == HB_W'(HIBER_WINDOW - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hb_cnt_q  <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      hb_cnt_q <= hb_end ? '0 : hb_cnt_q + 1'b1;
      if (hb_end) begin
        hi_ber_q  <= lock_q && (ber_cnt_q >= BER_W'(BER_LIM));
        ber_cnt_q <= '0;
      end else if (lock_q && i_rx_hdr_valid && !hdr_ok && (ber_cnt_q != BER_W'(BER_LIM))) begin
        ber_cnt_q <= ber_cnt_q + 1'b1;
      end
      // The flag only has meaning while the link is aligned.
      if (!lock_q) hi_ber_q <= 1'b0;
    end
  end

  assign o_hi_ber = hi_ber_q;
`else
  // BER window length is irrelevant without the monitor; folded into a constant 0.
  localparam logic HIBER_ZERO_WIN = (HIBER_WINDOW == 0);
  assign o_hi_ber = 1'b0 & HIBER_ZERO_WIN;
`endif

endmodule
